mem_access_unit: RTL and testbench

Bus-side memory access controller sitting directly downstream of the memory stage. It accepts one load/store request at a time, checks alignment, and generates lane-shifted write data and byte strobes. It runs a request/response transaction on the 64-bit data bus, right-aligns the returned load data, and then returns a one-cycle `mem_ready` with a response code. The memory stage holds its pipeline stall until that `mem_ready` pulse arrives.

---
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store bus access controller: alignment check, lane shifting of store data
// and strobes, request/response handshake with timeout and flush handling.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_req,
    input  logic [1:0]  mem_size,
    input  logic [63:0] mem_data_addr,
    input  logic [63:0] mem_data_write,
    output logic        mem_ready,
    output logic [1:0]  mem_resp,
    output logic [63:0] mem_data_read,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_write,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wstrb,
    input  logic        bus_resp_valid,
    input  logic [63:0] bus_rdata,
    input  logic        bus_resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t     state;
    state_t     next_state;
    logic [7:0] cnt;
    logic       abandon;
    logic [1:0] size_q;
    logic [2:0] off_q;
    logic       misaligned;
    logic       timeout_hit;
    logic       flushing;

    function automatic logic [7:0] base_strobe(input logic [1:0] size);
        case (size)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 64'h0000_0000_0000_00FF;
            2'b01:   return 64'h0000_0000_0000_FFFF;
            2'b10:   return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    assign misaligned = (mem_data_addr[2:0] & align_mask(mem_size)) != 3'b000;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // A flushed access still finishes on the bus but skips the DONE pulse.
    always_comb begin
        next_state    = state;
        mem_ready     = 1'b0;
        bus_req_valid = 1'b0;
        timeout_hit   = 1'b0;
        flushing      = abandon || !mem_valid;
        case (state)
            S_IDLE: begin
                if (mem_valid) next_state = misaligned ? S_DONE : S_REQ;
            end
            S_REQ: begin
                bus_req_valid = 1'b1;
                timeout_hit   = (cnt + 8'd1) == TIMEOUT_LIMIT;
                if (timeout_hit)        next_state = flushing ? S_IDLE : S_DONE;
                else if (bus_req_ready) next_state = S_WAIT;
            end
            S_WAIT: begin
                timeout_hit = (cnt + 8'd1) == TIMEOUT_LIMIT;
                if (timeout_hit || bus_resp_valid) next_state = flushing ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                mem_ready  = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt           <= 8'd0;
            abandon       <= 1'b0;
            size_q        <= 2'b00;
            off_q         <= 3'b000;
            bus_req_write <= 1'b0;
            bus_addr      <= 64'd0;
            bus_wdata     <= 64'd0;
            bus_wstrb     <= 8'd0;
            mem_resp      <= 2'b00;
            mem_data_read <= 64'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt     <= 8'd0;
                    abandon <= 1'b0;
                    if (mem_valid) begin
                        size_q        <= mem_size;
                        off_q         <= mem_data_addr[2:0];
                        bus_req_write <= mem_req;
                        bus_addr      <= {mem_data_addr[63:3], 3'b000};
                        bus_wdata     <= mem_data_write << {mem_data_addr[2:0], 3'b000};
                        bus_wstrb     <= mem_req ? (base_strobe(mem_size) << mem_data_addr[2:0]) : 8'd0;
                        mem_resp      <= misaligned ? 2'b01 : 2'b00;
                        mem_data_read <= 64'd0;
                    end
                end
                S_REQ, S_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (!mem_valid) abandon <= 1'b1;
                    // Timeout wins over a response landing in the same cycle.
                    if (timeout_hit) begin
                        mem_resp <= 2'b11;
                    end else if (state == S_WAIT && bus_resp_valid) begin
                        mem_resp      <= bus_resp_err ? 2'b10 : 2'b00;
                        mem_data_read <= bus_req_write ? 64'd0
                                       : (bus_rdata >> {off_q, 3'b000}) & size_mask(size_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// accesses compared against a byte-level behavioural model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_req = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic [63:0] mem_data_addr = 64'd0;
    logic [63:0] mem_data_write = 64'd0;
    logic        mem_ready;
    logic [1:0]  mem_resp;
    logic [63:0] mem_data_read;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic        bus_req_write;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_resp_valid = 1'b0;
    logic [63:0] bus_rdata = 64'd0;
    logic        bus_resp_err = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int          nready;
        int          rcyc;
        logic [1:0]  resp;
        logic [63:0] rd;
        int          nvalid;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [7:0]  strb;
        logic        wr;
    } obs_t;

    always #5 clock = ~clock;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_req(mem_req), .mem_size(mem_size),
        .mem_data_addr(mem_data_addr), .mem_data_write(mem_data_write),
        .mem_ready(mem_ready), .mem_resp(mem_resp), .mem_data_read(mem_data_read),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_write(bus_req_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_resp_valid(bus_resp_valid),
        .bus_rdata(bus_rdata), .bus_resp_err(bus_resp_err)
    );

    // Byte-lane model; cycle numbers count from the edge that samples mem_valid.
    function automatic obs_t model(input logic req, input logic [1:0] size,
                                   input logic [63:0] addr, input logic [63:0] wdata,
                                   input logic [63:0] rdata, input logic err,
                                   input int rdly, input int sdly, input bit flush);
        obs_t e;
        int off, n, t;
        off = int'(addr[2:0]);
        n = 1 << size;
        e.wr = req; e.addr = {addr[63:3], 3'b000};
        e.strb = 8'd0; e.wd = 64'd0; e.rd = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (i >= off) e.wd[8*i +: 8] = wdata[8*(i-off) +: 8];
            if (req && i >= off && i < off + n) e.strb[i] = 1'b1;
        end
        e.nready = flush ? 0 : 1;
        if (off % n != 0) begin
            e.resp = 2'd1; e.rcyc = 1; e.nvalid = 0;
        end else begin
            t = rdly + sdly + 2;
            e.nvalid = (rdly + 1 < TO) ? rdly + 1 : TO;
            if (t >= TO) begin
                e.resp = 2'd3; e.rcyc = TO + 1;
            end else begin
                e.resp = err ? 2'd2 : 2'd0; e.rcyc = t + 1;
                if (!req) for (int i = 0; i < n; i++) e.rd[8*i +: 8] = rdata[8*(off+i) +: 8];
            end
        end
        if (flush) e.rcyc = 0;
        return e;
    endfunction

    // Drives one access and a bus with rdly REQ cycles before ready and sdly WAIT cycles before response.
    task automatic run_access(input logic req, input logic [1:0] size, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] rdata, input logic err,
                              input int rdly, input int sdly, input int flush_at, output obs_t o);
        int phase, rcnt, wcnt;
        o.nready = 0; o.rcyc = 0; o.resp = 2'd0; o.rd = 64'd0; o.nvalid = 0;
        o.addr = 64'd0; o.wd = 64'd0; o.strb = 8'd0; o.wr = 1'b0;
        @(negedge clock);
        mem_valid = 1'b1; mem_req = req; mem_size = size;
        mem_data_addr = addr; mem_data_write = wdata;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        @(posedge clock);
        phase = 0; rcnt = 0; wcnt = 0;
        for (int cyc = 1; cyc <= TO + 4; cyc++) begin
            @(negedge clock);
            if (mem_ready) begin
                o.nready++; o.rcyc = cyc; o.resp = mem_resp; o.rd = mem_data_read;
                mem_valid = 1'b0;
            end
            if (bus_req_valid) begin
                if (o.nvalid == 0) begin
                    o.addr = bus_addr; o.wd = bus_wdata; o.strb = bus_wstrb; o.wr = bus_req_write;
                end
                o.nvalid++;
            end
            bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
            bus_resp_err = 1'($urandom); bus_rdata = {$urandom, $urandom};
            if (phase == 0 && bus_req_valid) begin
                bus_resp_valid = 1'($urandom_range(0, 1));
                if (rcnt == rdly) begin bus_req_ready = 1'b1; phase = 1; end
                rcnt++;
            end else if (phase == 1) begin
                if (wcnt == sdly) begin
                    bus_resp_valid = 1'b1; bus_rdata = rdata; bus_resp_err = err; phase = 2;
                end
                wcnt++;
            end
            if (cyc == flush_at) mem_valid = 1'b0;
        end
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        mem_valid = 1'b1; mem_data_addr = 64'h8000_0008; mem_size = 2'b11;
        #12;
        n_cmp++; if ({mem_ready, mem_resp, bus_req_valid, bus_req_write, bus_wstrb} !== 13'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h want 0", {mem_ready, mem_resp, bus_req_valid, bus_req_write, bus_wstrb});
        end
        n_cmp++; if (bus_addr !== 64'd0 || bus_wdata !== 64'd0 || mem_data_read !== 64'd0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h want 0", bus_addr, bus_wdata, mem_data_read);
        end
        mem_valid = 1'b0;
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_ld_d();
        obs_t o;
        run_access(1'b0, 2'b11, 64'h8000_0008, 64'hDEAD_BEEF_0000_1111, 64'h1122_3344_5566_7788, 1'b0, 1, 0, 0, o);
        n_cmp++; if (o.nready !== 1 || o.rcyc !== 4) begin
            n_fail++; $display("FAIL ld_d timing: got %0d pulses at cycle %0d want 1 at 4", o.nready, o.rcyc);
        end
        n_cmp++; if (o.resp !== 2'd0 || o.rd !== 64'h1122_3344_5566_7788) begin
            n_fail++; $display("FAIL ld_d resp/data: got %0d %h want 0 1122334455667788", o.resp, o.rd);
        end
        n_cmp++; if (o.strb !== 8'd0 || o.addr !== 64'h8000_0008 || o.wr !== 1'b0) begin
            n_fail++; $display("FAIL ld_d bus: got strb %h addr %h wr %b want 00 80000008 0", o.strb, o.addr, o.wr);
        end
    endtask

    task automatic test_sb_lane();
        obs_t o;
        run_access(1'b1, 2'b00, 64'h8000_0005, 64'h0000_0000_0000_00AB, 64'h0, 1'b0, 1, 0, 0, o);
        n_cmp++; if (o.strb !== 8'h20 || o.wd !== 64'h0000_AB00_0000_0000) begin
            n_fail++; $display("FAIL sb_lane: got strb %h wdata %h want 20 0000ab0000000000", o.strb, o.wd);
        end
        n_cmp++; if (o.addr !== 64'h8000_0000 || o.wr !== 1'b1) begin
            n_fail++; $display("FAIL sb_addr: got %h wr %b want 80000000 1", o.addr, o.wr);
        end
        n_cmp++; if (o.nready !== 1 || o.resp !== 2'd0 || o.rd !== 64'd0) begin
            n_fail++; $display("FAIL sb_resp: got %0d resp %0d rd %h want 1 0 0", o.nready, o.resp, o.rd);
        end
    endtask

    task automatic test_lh_off6();
        obs_t o;
        run_access(1'b0, 2'b01, 64'h8000_0016, 64'h0, 64'hBEEF_0000_0000_0000, 1'b0, 0, 0, 0, o);
        n_cmp++; if (o.resp !== 2'd0 || o.rd !== 64'h0000_0000_0000_BEEF) begin
            n_fail++; $display("FAIL lh_off6: got resp %0d rd %h want 0 beef", o.resp, o.rd);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_access(1'b0, 2'b10, 64'h8000_0002, 64'h0, 64'h0, 1'b0, 0, 0, 0, o);
        n_cmp++; if (o.nvalid !== 0 || o.rcyc !== 1 || o.resp !== 2'd1) begin
            n_fail++; $display("FAIL misaligned: got valid %0d cycle %0d resp %0d want 0 1 1", o.nvalid, o.rcyc, o.resp);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(1'b0, 2'b11, 64'h8000_0010, 64'h0, 64'h55, 1'b0, 10, 0, 0, o);
        n_cmp++; if (o.nvalid !== TO || o.rcyc !== TO + 1 || o.resp !== 2'd3 || o.nready !== 1) begin
            n_fail++; $display("FAIL timeout_stall: got valid %0d cycle %0d resp %0d n %0d want %0d %0d 3 1",
                               o.nvalid, o.rcyc, o.resp, o.nready, TO, TO + 1);
        end
        // Ready lands on the timeout edge; the following response is a stray.
        run_access(1'b0, 2'b11, 64'h8000_0010, 64'h0, 64'h55, 1'b0, TO - 1, 0, 0, o);
        n_cmp++; if (o.rcyc !== TO + 1 || o.resp !== 2'd3 || o.nready !== 1 || o.rd !== 64'd0) begin
            n_fail++; $display("FAIL timeout_late: got cycle %0d resp %0d n %0d rd %h want %0d 3 1 0",
                               o.rcyc, o.resp, o.nready, o.rd, TO + 1);
        end
    endtask

    task automatic test_bus_err();
        obs_t o;
        run_access(1'b0, 2'b10, 64'h8000_0024, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b1, 0, 0, 0, o);
        n_cmp++; if (o.resp !== 2'd2 || o.rcyc !== 3) begin
            n_fail++; $display("FAIL bus_err: got resp %0d cycle %0d want 2 3", o.resp, o.rcyc);
        end
    endtask

    task automatic test_flush();
        obs_t o;
        run_access(1'b0, 2'b11, 64'h8000_0030, 64'h0, 64'h77, 1'b0, 0, 1, 2, o);
        n_cmp++; if (o.nready !== 0) begin
            n_fail++; $display("FAIL flush_wait: got %0d pulses want 0", o.nready);
        end
        run_access(1'b0, 2'b11, 64'h8000_0030, 64'h0, 64'h77, 1'b0, 2, 0, 1, o);
        n_cmp++; if (o.nready !== 0 || o.nvalid !== 3) begin
            n_fail++; $display("FAIL flush_req: got %0d pulses %0d valid want 0 3", o.nready, o.nvalid);
        end
        run_access(1'b1, 2'b01, 64'h8000_0031, 64'h0, 64'h0, 1'b0, 0, 0, 0, o);
        n_cmp++; if (o.rcyc !== 1 || o.resp !== 2'd1) begin
            n_fail++; $display("FAIL flush_idle: got cycle %0d resp %0d want 1 1", o.rcyc, o.resp);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        mem_valid = 1'b1; mem_req = 1'b1; mem_size = 2'b11;
        mem_data_addr = 64'h8000_0040; mem_data_write = 64'hFFFF; bus_req_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        n_cmp++; if (bus_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre: got %b want 1", bus_req_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus_req_valid !== 1'b0 || mem_ready !== 1'b0 || bus_wstrb !== 8'd0 || bus_addr !== 64'd0) begin
            n_fail++; $display("FAIL rst_mid: got valid %b ready %b strb %h addr %h want 0 0 00 0",
                               bus_req_valid, mem_ready, bus_wstrb, bus_addr);
        end
        mem_valid = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        n_cmp++; if (bus_req_valid !== 1'b0 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_post: got %b %b want 0 0", bus_req_valid, mem_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        int nv;
        pat = 4'd0; nv = 0;
        @(negedge clock);
        mem_valid = 1'b1; mem_req = 1'b0; mem_size = 2'b01; mem_data_addr = 64'h8000_0051;
        @(posedge clock);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clock);
            pat[cyc-1] = mem_ready;
            if (bus_req_valid) nv++;
        end
        mem_valid = 1'b0;
        n_cmp++; if (pat !== 4'b0101 || nv !== 0) begin
            n_fail++; $display("FAIL back_to_back: got ready pattern %b valid %0d want 0101 0", pat, nv);
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic req, err;
        logic [1:0] size;
        logic [63:0] addr, wdata, rdata;
        int rdly, sdly, flush_at, n;
        for (int k = 0; k < 60; k++) begin
            req = 1'($urandom); err = 1'($urandom); size = 2'($urandom_range(0, 3));
            addr = {$urandom, $urandom}; wdata = {$urandom, $urandom}; rdata = {$urandom, $urandom};
            n = 1 << size;
            if ($urandom_range(0, 3) != 0) addr[2:0] = 3'(int'(addr[2:0]) / n * n);
            rdly = $urandom_range(0, 4); sdly = $urandom_range(0, 3);
            e = model(req, size, addr, wdata, rdata, err, rdly, sdly, 1'b0);
            flush_at = 0;
            if (e.rcyc > 1 && $urandom_range(0, 5) == 0) flush_at = $urandom_range(1, e.rcyc - 1);
            if (flush_at != 0) e = model(req, size, addr, wdata, rdata, err, rdly, sdly, 1'b1);
            run_access(req, size, addr, wdata, rdata, err, rdly, sdly, flush_at, o);
            n_cmp++; if (o.nready !== e.nready || o.rcyc !== e.rcyc) begin
                n_fail++; $display("FAIL rnd%0d ready: got %0d at %0d want %0d at %0d", k, o.nready, o.rcyc, e.nready, e.rcyc);
            end
            if (flush_at == 0) begin
                n_cmp++; if (o.resp !== e.resp || o.rd !== e.rd) begin
                    n_fail++; $display("FAIL rnd%0d resp: got %0d %h want %0d %h", k, o.resp, o.rd, e.resp, e.rd);
                end
            end
            n_cmp++; if (o.nvalid !== e.nvalid) begin
                n_fail++; $display("FAIL rnd%0d req_cycles: got %0d want %0d", k, o.nvalid, e.nvalid);
            end
            if (e.nvalid > 0) begin
                n_cmp++; if (o.addr !== e.addr || o.wd !== e.wd || o.strb !== e.strb || o.wr !== e.wr) begin
                    n_fail++; $display("FAIL rnd%0d bus: got %h %h %h %b want %h %h %h %b",
                                       k, o.addr, o.wd, o.strb, o.wr, e.addr, e.wd, e.strb, e.wr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ld_d();
        test_sb_lane();
        test_lh_off6();
        test_misaligned();
        test_timeout();
        test_bus_err();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
